// File: rtl/bcd_adder_seq.sv
// bcd_adder_seq: unsigned adder with iterative binary-to-BCD conversion.
//
// Adds two WIDTH-bit operands and converts the WIDTH+1 bit sum into NDIG
// packed BCD digits using shift-add-3 (double dabble), one sum bit per clock.
// Intended as the decimal front end for 7-segment display drivers.
//
// Parameters:
//   WIDTH - operand width in bits (sum is WIDTH+1 bits)
//   NDIG  - number of BCD output digits, digit 0 (units) in bcd[3:0]
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous reset, active-high
//   start - one-cycle request; a/b sampled on the same edge (IDLE only)
//   a, b  - unsigned operands
//   busy  - high while the conversion is running
//   done  - one-cycle pulse; bcd valid from this cycle, held until next done
//   bcd   - packed BCD result
//   ovf   - saturation flag (only with BCD_OVF_EN)
//
// Optional feature (macro BCD_OVF_EN):
//   When defined, a sum above 10^NDIG-1 saturates bcd to all nines and sets
//   ovf. When undefined, there is no ovf port and bcd = sum mod 10^NDIG.

module bcd_adder_seq #(
    parameter int WIDTH = 4,
    parameter int NDIG  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
`ifdef BCD_OVF_EN
    output logic [4*NDIG-1:0] bcd,
    output logic              ovf
`else
    output logic [4*NDIG-1:0] bcd
`endif
);

    localparam int SW = WIDTH + 1;
    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [BW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [BW-1:0]   adj;

`ifdef BCD_OVF_EN
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] BCD_MAX = pow10(NDIG) - 64'd1;

    logic ovf_pend_q, ovf_pend_d;
    logic ovf_q, ovf_d;
    logic [SW-1:0] sum_in;

    assign sum_in = SW'(a) + SW'(b);
`endif

    // Pre-shift correction: any digit >= 5 would exceed 9 after doubling,
    // so +3 makes the doubled value carry correctly into the next digit.
    always_comb begin
        adj = shreg_q;
        for (int i = 0; i < NDIG; i++) begin
            if (shreg_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = shreg_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
`ifdef BCD_OVF_EN
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is dropped so
                // that done can never repeat on consecutive cycles.
                if (start && !done_q) begin
                    sum_d   = SW'(a) + SW'(b);
                    shreg_d = '0;
                    cnt_d   = CW'(SW);
                    busy_d  = 1'b1;
                    state_d = S_CONV;
`ifdef BCD_OVF_EN
                    ovf_pend_d = 64'(sum_in) > BCD_MAX;
`endif
                end
            end
            S_CONV: begin
                // The carry out of the top digit falls off the end,
                // which gives the result modulo 10^NDIG.
                shreg_d = {adj[BW-2:0], sum_q[SW-1]};
                sum_d   = sum_q << 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = shreg_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
`ifdef BCD_OVF_EN
                ovf_d = ovf_pend_q;
                if (ovf_pend_q) begin
                    bcd_d = {NDIG{4'h9}};
                end
`endif
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
`ifdef BCD_OVF_EN
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
`ifdef BCD_OVF_EN
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
`ifdef BCD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bcd_adder_seq.sv
// tb_bcd_adder_seq: directed vector table plus control-path sequences
// for bcd_adder_seq at (4,2), (8,3) and (8,2).

module tb_bcd_adder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic [7:0]  a_v, b_v;
    logic [2:0]  busy, done;
    logic [7:0]  bcd0;
    logic [11:0] bcd1;
    logic [7:0]  bcd2;
    logic        ovf0, ovf1, ovf2;
    logic [2:0]  prev_done;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef BCD_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
    assign ovf0 = 1'b0;
    assign ovf1 = 1'b0;
    assign ovf2 = 1'b0;
`endif

    always #5 clk = ~clk;

    bcd_adder_seq #(.WIDTH(4), .NDIG(2)) u0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .a(a_v[3:0]), .b(b_v[3:0]),
        .busy(busy[0]), .done(done[0]),
`ifdef BCD_OVF_EN
        .bcd(bcd0), .ovf(ovf0)
`else
        .bcd(bcd0)
`endif
    );

    bcd_adder_seq #(.WIDTH(8), .NDIG(3)) u1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .a(a_v), .b(b_v),
        .busy(busy[1]), .done(done[1]),
`ifdef BCD_OVF_EN
        .bcd(bcd1), .ovf(ovf1)
`else
        .bcd(bcd1)
`endif
    );

    bcd_adder_seq #(.WIDTH(8), .NDIG(2)) u2 (
        .clk(clk), .rst(rst), .start(start[2]),
        .a(a_v), .b(b_v),
        .busy(busy[2]), .done(done[2]),
`ifdef BCD_OVF_EN
        .bcd(bcd2), .ovf(ovf2)
`else
        .bcd(bcd2)
`endif
    );

    typedef struct {
        int          idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] exp;
        bit          eovf;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] cur_bcd(input int idx);
        case (idx)
            0:       return {4'h0, bcd0};
            1:       return bcd1;
            default: return {4'h0, bcd2};
        endcase
    endfunction

    function automatic bit cur_ovf(input int idx);
        case (idx)
            0:       return ovf0;
            1:       return ovf1;
            default: return ovf2;
        endcase
    endfunction

    // Decimal reference: returns {ovf, 3 BCD digits}.
    function automatic logic [12:0] model(input int idx,
                                          input logic [7:0] av,
                                          input logic [7:0] bv);
        int s, lim, m;
        bit o;
        logic [11:0] r;
        if (idx == 0) s = int'(av[3:0]) + int'(bv[3:0]);
        else          s = int'(av) + int'(bv);
        lim = (idx == 1) ? 1000 : 100;
        m = s % lim;
        o = 1'b0;
        if (OVF && s >= lim) begin
            m = lim - 1;
            o = 1'b1;
        end
        r[3:0]  = 4'(m % 10);
        r[7:4]  = 4'((m / 10) % 10);
        r[11:8] = 4'(m / 100);
        return {o, r};
    endfunction

    task automatic pulse(input int idx, input logic [7:0] av,
                         input logic [7:0] bv);
        @(negedge clk);
        a_v = av;
        b_v = bv;
        start[idx] = 1'b1;
        @(posedge clk);
        #1;
        start[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, output int lat,
                             output int bcnt, output bit ok);
        lat = 0;
        bcnt = int'(busy[idx]);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done[idx]) begin
                ok = 1'b1;
                break;
            end
            bcnt += int'(busy[idx]);
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input int idx, input logic [7:0] av,
                       input logic [7:0] bv, output logic [11:0] got,
                       output bit govf, output int lat, output int bcnt);
        bit ok;
        pulse(idx, av, bv);
        wait_done(idx, lat, bcnt, ok);
        got = cur_bcd(idx);
        govf = cur_ovf(idx);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done[idx]), 32'd0);
    endtask

    // Continuous protocol checks: done never with busy, never two
    // cycles in a row, and every digit stays within 0..9.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                logic [11:0] v;
                chk("busy_and_done", 32'(busy[i] & done[i]), 32'd0);
                chk("done_repeat", 32'(prev_done[i] & done[i]), 32'd0);
                v = cur_bcd(i);
                for (int d = 0; d < 3; d++) begin
                    chk("digit_range", 32'(v[4*d +: 4] > 4'd9), 32'd0);
                end
            end
        end
        prev_done <= done;
    end

    initial begin
        logic [11:0] got;
        logic [12:0] m;
        bit govf, ok;
        int lat, bcnt, cnt;

        vt[0]  = '{0, 8'd7,   8'd5,   12'h012, 1'b0};
        vt[1]  = '{0, 8'd15,  8'd15,  12'h030, 1'b0};
        vt[2]  = '{0, 8'd0,   8'd0,   12'h000, 1'b0};
        vt[3]  = '{0, 8'd9,   8'd9,   12'h018, 1'b0};
        vt[4]  = '{0, 8'd8,   8'd2,   12'h010, 1'b0};
        vt[5]  = '{1, 8'd200, 8'd99,  12'h299, 1'b0};
        vt[6]  = '{1, 8'd255, 8'd255, 12'h510, 1'b0};
        vt[7]  = '{1, 8'd0,   8'd1,   12'h001, 1'b0};
        vt[8]  = '{1, 8'd128, 8'd127, 12'h255, 1'b0};
        vt[9]  = '{1, 8'd99,  8'd1,   12'h100, 1'b0};
        vt[10] = '{2, 8'd99,  8'd1,   OVF ? 12'h099 : 12'h000, OVF};
        vt[11] = '{2, 8'd45,  8'd54,  12'h099, 1'b0};
        vt[12] = '{2, 8'd50,  8'd50,  OVF ? 12'h099 : 12'h000, OVF};
        vt[13] = '{2, 8'd0,   8'd0,   12'h000, 1'b0};
        vt[14] = '{2, 8'd255, 8'd255, OVF ? 12'h099 : 12'h010, OVF};

        rst = 1'b1;
        start = 3'b000;
        a_v = 8'd0;
        b_v = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd0", 32'(bcd0), 32'd0);
        chk("reset_bcd1", 32'(bcd1), 32'd0);
        chk("reset_bcd2", 32'(bcd2), 32'd0);
        chk("reset_ovf", 32'({ovf0, ovf1, ovf2}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run(vt[i].idx, vt[i].a, vt[i].b, got, govf, lat, bcnt);
            chk($sformatf("vec%0d_bcd", i), 32'(got), 32'(vt[i].exp));
            chk($sformatf("vec%0d_ovf", i), 32'(govf), 32'(vt[i].eovf));
            chk($sformatf("vec%0d_latency", i), lat,
                (vt[i].idx == 0) ? 6 : 10);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt,
                (vt[i].idx == 0) ? 5 : 9);
        end

        // start held for three cycles: only the first is accepted.
        @(negedge clk);
        a_v = 8'd2;
        b_v = 8'd3;
        start[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start[0] = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            cnt += int'(done[0]);
        end
        chk("held_start_one_done", cnt, 1);
        chk("held_start_bcd", 32'(bcd0), 32'h05);

        // start during the done cycle is ignored; next cycle is accepted.
        pulse(0, 8'd1, 8'd2);
        wait_done(0, lat, bcnt, ok);
        a_v = 8'd4;
        b_v = 8'd4;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        chk("b2b_ignored_busy", 32'(busy[0]), 32'd0);
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            cnt += int'(done[0]);
        end
        chk("b2b_no_done", cnt, 0);
        chk("b2b_held_bcd", 32'(bcd0), 32'h03);
        run(0, 8'd4, 8'd4, got, govf, lat, bcnt);
        chk("after_b2b_bcd", 32'(got), 32'h08);

        // Reset in the middle of a conversion aborts it.
        pulse(0, 8'd9, 8'd9);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_bcd0", 32'(bcd0), 32'd0);
        chk("midrst_bcd1", 32'(bcd1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            cnt += int'(done[0]);
        end
        chk("midrst_no_done", cnt, 0);
        run(0, 8'd9, 8'd4, got, govf, lat, bcnt);
        chk("post_rst_bcd", 32'(got), 32'h13);
        chk("post_rst_latency", lat, 6);

        // Random operands against the decimal reference.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            int idx;
            idx = i % 3;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            m = model(idx, ra, rb);
            run(idx, ra, rb, got, govf, lat, bcnt);
            chk($sformatf("rand%0d_bcd", i), 32'(got), 32'(m[11:0]));
            chk($sformatf("rand%0d_ovf", i), 32'(govf), 32'(m[12]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
